// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button event decoder and its neighbours.
//   btn_state_t        : decoder FSM state encoding
//   BTN_LONG_DEFAULT   : default hold time to long press (1 s at 100 MHz)
//   BTN_REPEAT_DEFAULT : default auto-repeat period (250 ms at 100 MHz)
// The timing constants are also used to configure the debouncer.
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    localparam int unsigned BTN_LONG_DEFAULT   = 100_000_000;
    localparam int unsigned BTN_REPEAT_DEFAULT = 25_000_000;

endpackage

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns a clean, debounced button level into one-cycle event pulses for the
// set/adjust control logic. One instance per button.
//
// Parameters:
//   LONG_PRESS_CYCLES : cycles from press to long_press (>= 2)
//   REPEAT_CYCLES     : cycles between repeat pulses while long-held (>= 2)
//   CNT_W             : hold counter width, 2**CNT_W > max of the above
//
// Ports:
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   btn_level     in  debounced synchronous button level (1 = pressed)
//   press_pulse   out one-cycle pulse on press edge
//   release_pulse out one-cycle pulse on release edge
//   short_press   out one-cycle pulse on release before long-press threshold
//   long_press    out one-cycle pulse when hold reaches LONG_PRESS_CYCLES
//   repeat_pulse  out one-cycle pulse every REPEAT_CYCLES while long-held
//   held          out level, high while PRESSED or LONG_HELD
//
// Build option:
//   BTN_AUTOREPEAT_EN : when defined, repeat_pulse is generated; otherwise it
//                       is tied low and REPEAT_CYCLES only feeds the
//                       parameter sanity checks.
// -----------------------------------------------------------------------------
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_DEFAULT,
    parameter int unsigned REPEAT_CYCLES     = BTN_REPEAT_DEFAULT,
    parameter int unsigned CNT_W             = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    // Elaboration-time parameter sanity checks.
    if (LONG_PRESS_CYCLES < 2) begin : g_long_too_small
        $error("LONG_PRESS_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_repeat_too_small
        $error("REPEAT_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(LONG_PRESS_CYCLES) ||
        (64'd1 << CNT_W) <= 64'(REPEAT_CYCLES)) begin : g_cnt_too_narrow
        $error("CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    btn_state_t       r_state;
    btn_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_btn_q;

    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_long;
    logic             r_held;
    logic             w_press_next;
    logic             w_release_next;
    logic             w_short_next;
    logic             w_long_next;
`ifdef BTN_AUTOREPEAT_EN
    logic             r_repeat;
    logic             w_repeat_next;
`endif

    // Next-state, counter and pulse logic. Release is tested before any
    // threshold so that a simultaneous release always wins.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_short_next   = 1'b0;
        w_long_next    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_repeat_next  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // r_btn_q resets high, so a button held through reset must
                // be seen low before it can register a press.
                if (btn_level && !r_btn_q) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    w_state_next   = IDLE;
                    w_release_next = 1'b1;
                    w_short_next   = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_next = LONG_HELD;
                    w_cnt_next   = '0;
                    w_long_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!btn_level) begin
                    w_state_next   = IDLE;
                    w_release_next = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (r_cnt == REPEAT_LAST) begin
                    w_cnt_next    = '0;
                    w_repeat_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
                // Without auto-repeat the counter simply rests at zero here.
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_btn_q   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_btn_q   <= btn_level;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_short   <= w_short_next;
            r_long    <= w_long_next;
            r_held    <= (w_state_next != IDLE);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat_next;
        end
    end
    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_press   = r_short;
    assign long_press    = r_long;
    assign held          = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
// Self-checking bench for button_event_decoder with LONG_PRESS_CYCLES=8,
// REPEAT_CYCLES=4, CNT_W=4. Repeat expectations follow BTN_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

    localparam int LONG_C = 8;
    localparam int REP_C  = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    button_event_decoder #(
        .LONG_PRESS_CYCLES(LONG_C),
        .REPEAT_CYCLES    (REP_C),
        .CNT_W            (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic press;
        logic rel;
        logic short_p;
        logic long_p;
        logic rep;
        logic held;
    } exp_t;

    typedef struct {
        logic lvl;
        exp_t exp;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Reference model: tracks the number of consecutive high samples since
    // the accepted press edge and derives events from that run length.
    logic m_prev;
    logic m_in;
    int   m_run;

    task automatic model_reset();
        m_prev = 1'b1;
        m_in   = 1'b0;
        m_run  = 0;
    endtask

    task automatic model_step(input logic cur, output exp_t e);
        e = '0;
        if (cur && !m_in && !m_prev) begin
            e.press = 1'b1;
            m_in    = 1'b1;
            m_run   = 1;
        end else if (cur && m_in) begin
            m_run = m_run + 1;
            if (m_run == LONG_C + 1)
                e.long_p = 1'b1;
            else if (AR_EN && m_run > LONG_C + 1 && ((m_run - LONG_C - 1) % REP_C) == 0)
                e.rep = 1'b1;
        end else if (!cur && m_in) begin
            e.rel     = 1'b1;
            e.short_p = (m_run <= LONG_C);
            m_in      = 1'b0;
            m_run     = 0;
        end
        e.held = m_in;
        m_prev = cur;
    endtask

    function automatic exp_t dut_out();
        return {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
    endfunction

    task automatic compare(input string name, input exp_t want);
        exp_t got;
        got = dut_out();
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got={p,r,s,l,rp,h}=%06b required=%06b",
                     name, cyc, got, want);
        end
    endtask

    // Drive one sample; expectation comes from the table when use_tbl is set,
    // otherwise from the model. Pushed on drive, popped after the edge.
    task automatic drive(input logic lvl, input bit use_tbl, input exp_t tbl_e,
                         input string name);
        exp_t m_e;
        exp_t want;
        @(negedge clk);
        btn_level = lvl;
        model_step(lvl, m_e);
        sb_q.push_back(use_tbl ? tbl_e : m_e);
        @(posedge clk);
        #1;
        cyc++;
        want = sb_q.pop_front();
        compare(name, want);
        $display("cyc=%0d %s lvl=%0b out=%06b exp=%06b", cyc, name, lvl, dut_out(), want);
    endtask

    task automatic run_level(input logic lvl, input int n, input string name);
        for (int i = 0; i < n; i++) drive(lvl, 1'b0, '0, name);
    endtask

    vec_t tbl[6];

    initial begin
        // Short press: 3 high cycles. Fields {press,rel,short,long,rep,held}.
        tbl[0] = '{lvl: 1'b0, exp: 6'b000000};
        tbl[1] = '{lvl: 1'b1, exp: 6'b100001};
        tbl[2] = '{lvl: 1'b1, exp: 6'b000001};
        tbl[3] = '{lvl: 1'b1, exp: 6'b000001};
        tbl[4] = '{lvl: 1'b0, exp: 6'b011000};
        tbl[5] = '{lvl: 1'b0, exp: 6'b000000};

        rst_n     = 1'b0;
        btn_level = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven short press
        for (int i = 0; i < 6; i++) begin
            exp_t dummy;
            model_step(tbl[i].lvl, dummy);
            model_prev_fix: begin end
            @(negedge clk);
            btn_level = tbl[i].lvl;
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            cyc++;
            compare("tbl_short", sb_q.pop_front());
            $display("cyc=%0d tbl[%0d] lvl=%0b out=%06b exp=%06b", cyc, i, tbl[i].lvl,
                     dut_out(), tbl[i].exp);
        end

        // Long hold of 20 cycles: long at +8, repeats at +4/+8/+12
        run_level(1'b1, 21, "long_hold");
        run_level(1'b0, 2, "long_release");

        // Release exactly when the long threshold would be reached
        run_level(1'b1, LONG_C, "edge_hold");
        run_level(1'b0, 2, "edge_release");
        // One beyond: long fires, release gives no short
        run_level(1'b1, LONG_C + 1, "over_hold");
        run_level(1'b0, 2, "over_release");

        // Reset mid LONG_HELD, button stays high through reset release
        run_level(1'b1, LONG_C + 3, "pre_reset_hold");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare("async_reset_outputs", 6'b000000);
        @(posedge clk);
        #1;
        compare("in_reset_outputs", 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        run_level(1'b1, 4, "post_reset_high");
        run_level(1'b0, 1, "post_reset_low");
        run_level(1'b1, 2, "post_reset_press");
        run_level(1'b0, 2, "post_reset_release");

        // 30-cycle hold: single long_press, repeats only with auto-repeat
        run_level(1'b1, 30, "hold30");
        run_level(1'b0, 2, "hold30_release");

        // Back-to-back presses separated by one low cycle, plus a glitch
        run_level(1'b1, 2, "b2b_a");
        run_level(1'b0, 1, "b2b_gap");
        run_level(1'b1, 2, "b2b_b");
        run_level(1'b0, 1, "b2b_gap2");
        run_level(1'b1, 1, "glitch");
        run_level(1'b0, 2, "glitch_release");

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
